// File: rtl/traffic_pkg.sv
// ---------------------------------------------------------------------------
// traffic_pkg
// Shared types for the intersection controller:
//   light_t  - lamp driver codes (RED/YELLOW/GREEN/OFF)
//   state_t  - phase sequencer states
//   dir_t    - green direction (NS/EW)
//   lamps_t  - bundled lamp outputs (ns light, ew light, walk)
// decode_lamps() maps a phase state to its lamp outputs.
// Optional feature macro: NIGHT_FLASH_EN (adds ST_FLASH).
// ---------------------------------------------------------------------------
package traffic_pkg;

  typedef enum logic [1:0] {
    RED    = 2'b00,
    YELLOW = 2'b01,
    GREEN  = 2'b10,
    OFF    = 2'b11
  } light_t;

  typedef enum logic [2:0] {
    ST_NS_GREEN,
    ST_NS_YELLOW,
    ST_EW_GREEN,
    ST_EW_YELLOW,
    ST_ALL_RED,
    ST_PED_WALK,
    ST_PED_CLEAR
`ifdef NIGHT_FLASH_EN
    , ST_FLASH
`endif
  } state_t;

  typedef enum logic {
    DIR_NS = 1'b0,
    DIR_EW = 1'b1
  } dir_t;

  typedef struct packed {
    light_t ns;
    light_t ew;
    logic   walk;
  } lamps_t;

  // Lamp outputs for a state. Every state not listed is all-red, so no
  // encoding can ever show conflicting greens or walk with a non-red light.
  function automatic lamps_t decode_lamps(input state_t st);
    lamps_t l;
    l = '{ns: RED, ew: RED, walk: 1'b0};
    case (st)
      ST_NS_GREEN:  l.ns   = GREEN;
      ST_NS_YELLOW: l.ns   = YELLOW;
      ST_EW_GREEN:  l.ew   = GREEN;
      ST_EW_YELLOW: l.ew   = YELLOW;
      ST_PED_WALK:  l.walk = 1'b1;
`ifdef NIGHT_FLASH_EN
      // First half of the flash cycle; the OFF half is overlaid by the top.
      ST_FLASH:     l.ns   = YELLOW;
`endif
      default:      ;
    endcase
    return l;
  endfunction

endpackage

// File: rtl/phase_timer.sv
// ---------------------------------------------------------------------------
// phase_timer
// Tick-enabled, clearable, saturating phase counter.
//   clk, reset  - clock, asynchronous active-high reset
//   tick_i      - count enable strobe
//   clr_i       - on a tick, return the count to zero instead of counting
//   cnt_o [CW]  - ticks elapsed; holds at SAT_VAL once reached
// ---------------------------------------------------------------------------
module phase_timer #(
  parameter int unsigned CW      = 7,
  parameter int unsigned SAT_VAL = 89
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick_i,
  input  logic          clr_i,
  output logic [CW-1:0] cnt_o
);

  localparam logic [CW-1:0] SAT = CW'(SAT_VAL);

  logic [CW-1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (tick_i) begin
      if (clr_i)             cnt_d = '0;
      else if (cnt_q != SAT) cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/intersection_ctrl.sv
// ---------------------------------------------------------------------------
// intersection_ctrl
// Two-way intersection scheduler: N/S approach, E/W approach and a
// pedestrian crossing share the junction through green / yellow / all-red
// phases with demand-driven green extension and a latched walk request.
//
// Ports:
//   clk, reset        - clock, asynchronous active-high reset
//   tick              - timing strobe; all timing advances only when high
//   req_ns, req_ew    - vehicle sensors (level, not latched)
//   ped_req           - pedestrian button (latched into ped_pending)
//   night             - night flash request (only with NIGHT_FLASH_EN)
//   light_ns/light_ew - lamp codes, RED=00 YELLOW=01 GREEN=10 OFF=11
//   walk              - pedestrian walk lamp
//   ped_pending       - latched pedestrian request
//   phase_cnt [CW]    - ticks elapsed in the current state
//
// Optional feature macro: NIGHT_FLASH_EN (night input, FLASH state).
// All outputs are registered and change on the edge committing a new state.
// ---------------------------------------------------------------------------
module intersection_ctrl #(
  parameter int unsigned GREEN_MIN = 30,
  parameter int unsigned GREEN_MAX = 90,
  parameter int unsigned YELLOW_T  = 5,
  parameter int unsigned ALLRED_T  = 2,
  parameter int unsigned WALK_T    = 20,
  parameter int unsigned CW        = 7   // 2**CW must exceed GREEN_MAX
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          tick,
  input  logic          req_ns,
  input  logic          req_ew,
  input  logic          ped_req,
`ifdef NIGHT_FLASH_EN
  input  logic          night,
`endif
  output logic [1:0]    light_ns,
  output logic [1:0]    light_ew,
  output logic          walk,
  output logic          ped_pending,
  output logic [CW-1:0] phase_cnt
);

  import traffic_pkg::*;

  // Exit points: a state of length T leaves on the tick where phase_cnt==T-1.
  localparam logic [CW-1:0] GMIN_LAST   = CW'(GREEN_MIN - 1);
  localparam logic [CW-1:0] GMAX_LAST   = CW'(GREEN_MAX - 1);
  localparam logic [CW-1:0] YELLOW_LAST = CW'(YELLOW_T - 1);
  localparam logic [CW-1:0] ALLRED_LAST = CW'(ALLRED_T - 1);
  localparam logic [CW-1:0] WALK_LAST   = CW'(WALK_T - 1);

  state_t state_q, state_d;
  dir_t   last_dir_q, last_dir_d;
  logic   ped_pending_q, ped_pending_d;
  lamps_t lamps_q, lamps_d;
  logic   state_change;
  state_t resume_green;

`ifdef NIGHT_FLASH_EN
  logic flash_off_q, flash_off_d;
`endif

  // Counter restarts on the edge that commits a transition, otherwise
  // counts ticks and parks at GREEN_MAX-1 (resting green).
  phase_timer #(
    .CW      (CW),
    .SAT_VAL (GREEN_MAX - 1)
  ) u_phase_timer (
    .clk    (clk),
    .reset  (reset),
    .tick_i (tick),
    .clr_i  (state_change),
    .cnt_o  (phase_cnt)
  );

  // The green following any all-red interval goes to the approach that did
  // not have the last green.
  assign resume_green = (last_dir_q == DIR_NS) ? ST_EW_GREEN : ST_NS_GREEN;

  // NOTE: every signal assigned here gets a default before any branch, so
  // no path leaves it unassigned and no latch is inferred.
  always_comb begin
    state_d    = state_q;
    last_dir_d = last_dir_q;

    if (tick) begin
      case (state_q)
        ST_NS_GREEN: begin
          if ((req_ew || ped_pending_q) &&
              ((phase_cnt >= GMIN_LAST && !req_ns) || phase_cnt == GMAX_LAST)) begin
            state_d    = ST_NS_YELLOW;
            last_dir_d = DIR_NS;
          end
        end
        ST_EW_GREEN: begin
          if ((req_ns || ped_pending_q) &&
              ((phase_cnt >= GMIN_LAST && !req_ew) || phase_cnt == GMAX_LAST)) begin
            state_d    = ST_EW_YELLOW;
            last_dir_d = DIR_EW;
          end
        end
        ST_NS_YELLOW, ST_EW_YELLOW: begin
          if (phase_cnt == YELLOW_LAST) state_d = ST_ALL_RED;
        end
        ST_ALL_RED: begin
          if (phase_cnt == ALLRED_LAST) begin
            state_d = ped_pending_q ? ST_PED_WALK : resume_green;
`ifdef NIGHT_FLASH_EN
            if (night) state_d = ST_FLASH;
`endif
          end
        end
        ST_PED_WALK: begin
          if (phase_cnt == WALK_LAST) state_d = ST_PED_CLEAR;
        end
        ST_PED_CLEAR: begin
          if (phase_cnt == ALLRED_LAST) state_d = resume_green;
        end
`ifdef NIGHT_FLASH_EN
        ST_FLASH: begin
          if (!night) state_d = ST_ALL_RED;
        end
`endif
        default: state_d = ST_ALL_RED;
      endcase
    end
  end

  assign state_change = (state_d != state_q);

  // Pedestrian latch: button is ignored while walking, and the clear on
  // entry to PED_WALK overrides a press in the same cycle.
  always_comb begin
    ped_pending_d = ped_pending_q | (ped_req && (state_q != ST_PED_WALK));
    if (state_change && state_d == ST_PED_WALK) ped_pending_d = 1'b0;
  end

  // Lamps are decoded from the next state so the registered outputs switch
  // on the same edge as the state register.
  always_comb begin
    lamps_d = decode_lamps(state_d);
`ifdef NIGHT_FLASH_EN
    // Flash starts in the lit half on entry and toggles on every tick.
    flash_off_d = 1'b0;
    if (state_d == ST_FLASH && state_q == ST_FLASH) flash_off_d = flash_off_q ^ tick;
    if (flash_off_d) begin
      lamps_d.ns = OFF;
      lamps_d.ew = OFF;
    end
`endif
  end

  // NOTE: state registers use non-blocking assignments so every flop
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= ST_ALL_RED;
      last_dir_q    <= DIR_EW;
      ped_pending_q <= 1'b0;
      lamps_q       <= '{ns: RED, ew: RED, walk: 1'b0};
    end else begin
      state_q       <= state_d;
      last_dir_q    <= last_dir_d;
      ped_pending_q <= ped_pending_d;
      lamps_q       <= lamps_d;
    end
  end

`ifdef NIGHT_FLASH_EN
  always_ff @(posedge clk or posedge reset) begin
    if (reset) flash_off_q <= 1'b0;
    else       flash_off_q <= flash_off_d;
  end
`endif

  assign light_ns    = lamps_q.ns;
  assign light_ew    = lamps_q.ew;
  assign walk        = lamps_q.walk;
  assign ped_pending = ped_pending_q;

endmodule

// File: doc/intersection_ctrl.md
Name: intersection_ctrl

Overview:
- Two-way intersection scheduler. Shares the crossing between three requesters: the north/south vehicle approach, the east/west vehicle approach, and a pedestrian crossing.
- Sequences green, yellow and all-red phases with demand-driven green extension and a latched pedestrian walk phase.
- Drives per-approach light codes consumed by the lamp drivers. Timing comes from an external `tick` time base (e.g. 1 Hz strobe).

Parameters:
- GREEN_MIN, 30, minimum green duration in ticks.
- GREEN_MAX, 90, maximum green duration in ticks while the own approach keeps requesting.
- YELLOW_T, 5, yellow duration in ticks.
- ALLRED_T, 2, all-red clearance duration in ticks.
- WALK_T, 20, pedestrian walk duration in ticks.
- CW, 7, phase counter width; must satisfy 2^CW > GREEN_MAX.

Ports:
- clk  in  1  clock.
- reset  in  1  asynchronous, active-high reset.
- tick  in  1  one-cycle timing strobe; all timing advances only on cycles with tick=1.
- req_ns  in  1  N/S vehicle sensor, level, not latched.
- req_ew  in  1  E/W vehicle sensor, level, not latched.
- ped_req  in  1  pedestrian button, pulse or level, latched internally.
- light_ns  out  2  N/S light code.
- light_ew  out  2  E/W light code.
- walk  out  1  pedestrian walk lamp.
- ped_pending  out  1  latched pedestrian request.
- phase_cnt  out  CW  ticks elapsed in the current state.

Behaviour:
- Light encoding: RED=2'b00, YELLOW=2'b01, GREEN=2'b10, OFF=2'b11 (OFF is used only by the optional feature).
- States and outputs:
  - NS_GREEN: ns GREEN, ew RED.
  - NS_YELLOW: ns YELLOW, ew RED.
  - EW_GREEN: ns RED, ew GREEN.
  - EW_YELLOW: ns RED, ew YELLOW.
  - ALL_RED: both RED.
  - PED_WALK: both RED, walk=1.
  - PED_CLEAR: both RED, walk=0.
- All outputs are registered; they change on the clock edge that commits the state change.
- Reset: state=ALL_RED, last_dir=EW, phase_cnt=0, ped_pending=0, both lights RED, walk=0.
- Transitions are evaluated only when tick=1. On the edge where a transition fires, phase_cnt goes to 0. Otherwise, on a tick, phase_cnt increments and saturates at GREEN_MAX-1.
- A fixed-length state of duration T exits on the tick where phase_cnt==T-1. It therefore lasts exactly T ticks.
- Green exit (shown for NS; EW is symmetric with req_ns):
  - Competing demand = req_ew | ped_pending.
  - Exit to yellow when competing demand AND ((phase_cnt>=GREEN_MIN-1 AND !req_ns) OR phase_cnt==GREEN_MAX-1).
  - With no competing demand, green rests indefinitely and phase_cnt saturates.
- YELLOW lasts YELLOW_T ticks, then goes to ALL_RED. The green direction is recorded in last_dir on yellow entry.
- ALL_RED lasts ALLRED_T ticks, then:
  - goes to PED_WALK if ped_pending;
  - otherwise goes to the green opposite last_dir.
- PED_WALK lasts WALK_T ticks, then goes to PED_CLEAR. PED_CLEAR lasts ALLRED_T ticks, then goes to the green opposite last_dir.
- ped_pending:
  - Set on any cycle with ped_req=1.
  - Cleared on the edge entering PED_WALK. Clear wins over a simultaneous set.
  - ped_req during PED_WALK is ignored. ped_req during PED_CLEAR is latched.
- No state ever drives GREEN or YELLOW on both approaches. No state drives walk=1 with any light other than RED.
- tick=0 freezes state and counter; asynchronous inputs are still latched.

Optional Feature:
- Macro: NIGHT_FLASH_EN.
- With the macro defined:
  - Adds input `night` (1 bit) and state FLASH.
  - While `night`=1, the next ALL_RED exit enters FLASH instead of its normal target.
  - In FLASH: light_ns alternates YELLOW/OFF and light_ew alternates RED/OFF on each tick, starting YELLOW/RED. walk=0 and ped_pending is held.
  - Leaving FLASH: on the tick after `night`=0, go to ALL_RED, then resume the normal sequence.
- Without the macro: no `night` port, no FLASH state, and OFF is never driven.

Decomposition:
- Shared package traffic_pkg holds:
  - light codes RED/YELLOW/GREEN/OFF;
  - the phase state enum;
  - the direction enum (NS/EW).
- One sub-module, phase_timer: a tick-enabled, clearable, saturating CW-bit counter producing phase_cnt.

Test Plan:
1. Reset, tick every cycle, no requests → ALL_RED for 2 ticks, then light_ns=GREEN indefinitely; phase_cnt saturates at 89.
2. req_ew=1 held, req_ns=0 → NS GREEN exactly 30 ticks, YELLOW 5, ALL_RED 2, then EW GREEN.
3. req_ns=1 and req_ew=1 held → NS GREEN exactly 90 ticks, then YELLOW; EW then also gets 90 ticks.
4. Single-cycle ped_req at tick 3 of NS green, no vehicle requests:
   - NS green exits at tick 30; YELLOW 5; ALL_RED 2;
   - PED_WALK 20 with walk=1 and both lights RED, ped_pending=0;
   - PED_CLEAR 2, then EW GREEN.
5. Assert reset mid NS_YELLOW → immediately both RED, walk=0, phase_cnt=0, ped_pending=0.
6. tick held 0 for 50 cycles during EW green → no change to state or phase_cnt; a ped_req pulse in that window still sets ped_pending.
